// File: rtl/parking_pkg.sv
// Shared definitions for the parking-system output path.
//   stretch_state_t : pulse_stretcher FSM encoding (IDLE, HOLD, GAP)
//   SYNC_STAGES     : depth of the common input synchronizer
//   max_int         : elaboration-time helper for sizing counters
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_sync_edge.sv
// sync_edge: brings an asynchronous event line into the clk domain and
// flags its rising edge.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset, clears every flop
//   i_in   : asynchronous event input
//   o_rise : one-cycle pulse when the synchronized input goes 0 -> 1
// Because all flops reset to 0, an input that is already high at reset
// release produces one rise, so a held-high line still counts as an event.
module sync_edge
  import parking_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_in};
      r_hist <= r_sync[STAGES-1];
    end
  end

  // Driven only by flops, so no combinational path from i_in.
  assign o_rise = r_sync[STAGES-1] & ~r_hist;

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns short event pulses into a level held for
// HOLD_CYCLES, followed by a forced low gap of GAP_CYCLES.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset, aborts any hold/gap
//   inPulse   : asynchronous event input, rising-edge triggered
//   outLevel  : stretched level (registered)
//   busy      : high whenever the FSM is not IDLE (registered)
//   dropped   : one-cycle strobe when a detected edge is ignored (registered)
//   dbg_state : current FSM state, for observation only
// Handshake: none; inPulse is a free-running event line, and a rise that
// cannot be accepted is reported on dropped and then forgotten.
module pulse_stretcher
  import parking_pkg::*;
#(
  parameter int HOLD_CYCLES = 1_000_000,  // >= 1
  parameter int GAP_CYCLES  = 1_000,      // 0 = no gap
  parameter bit RETRIGGER   = 1'b1        // 1 = rise in HOLD restarts hold
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inPulse,
  output logic           outLevel,
  output logic           busy,
  output logic           dropped,
  output stretch_state_t dbg_state
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  =
    CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  stretch_state_t   r_state;
  stretch_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dropped_nxt;
  logic             w_rise;
  logic             r_out;
  logic             r_busy;
  logic             r_dropped;

  sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .i_in  (inPulse),
    .o_rise(w_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      // Outputs are registered from the next state so they line up with
      // the state they describe.
      r_out     <= (w_state_nxt == HOLD);
      r_busy    <= (w_state_nxt != IDLE);
      r_dropped <= w_dropped_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_dropped_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end
      end
      HOLD: begin
        // Reload wins over expiry, so a retrigger on the last hold cycle
        // keeps the level high without a glitch.
        if (w_rise && RETRIGGER) begin
          w_cnt_nxt = HOLD_LOAD;
        end else begin
          if (w_rise) begin
            w_dropped_nxt = 1'b1;
          end
          if (r_cnt == '0) begin
            if (GAP_CYCLES == 0) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = GAP;
              w_cnt_nxt   = GAP_LOAD;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end
      GAP: begin
        // Rises are never queued; even one on the final gap cycle is lost.
        if (w_rise) begin
          w_dropped_nxt = 1'b1;
        end
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign outLevel  = r_out;
  assign busy      = r_busy;
  assign dropped   = r_dropped;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher with HOLD=8, GAP=4. Three instances share the
// input: a = retrigger/gap 4, b = no retrigger/gap 4, c = retrigger/gap 0.
// Trace index c is sampled at the c-th falling edge of a capture; a pulse
// driven at index p is first sampled on the following rising edge, so its
// hold begins at trace index p+3.
module tb_pulse_stretcher;
  import parking_pkg::*;

  logic clk;
  logic rst;
  logic in_pulse;
  logic out_a, busy_a, drop_a;
  logic out_b, busy_b, drop_b;
  logic out_c, busy_c, drop_c;
  stretch_state_t dbg_a, dbg_b, dbg_c;

  int n_tests;
  int n_fail;

  logic [255:0] t_out_a, t_busy_a, t_drop_a;
  logic [255:0] t_out_b, t_busy_b, t_drop_b;
  logic [255:0] t_out_c, t_busy_c, t_drop_c;

  pulse_stretcher #(.HOLD_CYCLES(8), .GAP_CYCLES(4), .RETRIGGER(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .inPulse(in_pulse),
    .outLevel(out_a), .busy(busy_a), .dropped(drop_a), .dbg_state(dbg_a)
  );
  pulse_stretcher #(.HOLD_CYCLES(8), .GAP_CYCLES(4), .RETRIGGER(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .inPulse(in_pulse),
    .outLevel(out_b), .busy(busy_b), .dropped(drop_b), .dbg_state(dbg_b)
  );
  pulse_stretcher #(.HOLD_CYCLES(8), .GAP_CYCLES(0), .RETRIGGER(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .inPulse(in_pulse),
    .outLevel(out_c), .busy(busy_c), .dropped(drop_c), .dbg_state(dbg_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- trace utilities ----------------
  function automatic int cnt1(input logic [255:0] v);
    int n = 0;
    for (int i = 0; i < 256; i++) if (v[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first1(input logic [255:0] v);
    for (int i = 0; i < 256; i++) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int last1(input logic [255:0] v);
    for (int i = 255; i >= 0; i--) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  // ---------------- driver ----------------
  // Drives up to two pulses (start index, length) and records all outputs.
  task automatic capture(input int n, input int p1, input int l1,
                         input int p2, input int l2);
    t_out_a = '0; t_busy_a = '0; t_drop_a = '0;
    t_out_b = '0; t_busy_b = '0; t_drop_b = '0;
    t_out_c = '0; t_busy_c = '0; t_drop_c = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      t_out_a[c] = out_a; t_busy_a[c] = busy_a; t_drop_a[c] = drop_a;
      t_out_b[c] = out_b; t_busy_b[c] = busy_b; t_drop_b[c] = drop_b;
      t_out_c[c] = out_c; t_busy_c[c] = busy_c; t_drop_c[c] = drop_c;
      in_pulse = ((c >= p1) && (c < p1 + l1)) || ((c >= p2) && (c < p2 + l2));
    end
    in_pulse = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_pulse = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL reset_out got %b exp 0", out_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    n_tests++; if (drop_a !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b exp 0", drop_a); end
    n_tests++; if (dbg_a !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_a); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_isolated();
    capture(40, 5, 1, -100, 0);
    n_tests++; if (cnt1(t_out_a) !== 8) begin n_fail++; $display("FAIL iso_out_len got %0d exp 8", cnt1(t_out_a)); end
    n_tests++; if (first1(t_out_a) !== 8) begin n_fail++; $display("FAIL iso_out_first got %0d exp 8", first1(t_out_a)); end
    n_tests++; if (last1(t_out_a) !== 15) begin n_fail++; $display("FAIL iso_out_last got %0d exp 15", last1(t_out_a)); end
    n_tests++; if (cnt1(t_busy_a) !== 12) begin n_fail++; $display("FAIL iso_busy_len got %0d exp 12", cnt1(t_busy_a)); end
    n_tests++; if (last1(t_busy_a) !== 19) begin n_fail++; $display("FAIL iso_busy_last got %0d exp 19", last1(t_busy_a)); end
    n_tests++; if (cnt1(t_drop_a) !== 0) begin n_fail++; $display("FAIL iso_drop got %0d exp 0", cnt1(t_drop_a)); end
    n_tests++; if (cnt1(t_out_b) !== 8) begin n_fail++; $display("FAIL iso_b_out_len got %0d exp 8", cnt1(t_out_b)); end
    n_tests++; if (cnt1(t_busy_c) !== 8) begin n_fail++; $display("FAIL iso_c_busy_len got %0d exp 8", cnt1(t_busy_c)); end
  endtask

  task automatic test_retrigger();
    // Second rise seen on hold cycle 4; the restarted hold begins 5 cycles in.
    capture(50, 5, 1, 10, 1);
    n_tests++; if (cnt1(t_out_a) !== 13) begin n_fail++; $display("FAIL rt_out_len got %0d exp 13", cnt1(t_out_a)); end
    n_tests++; if (last1(t_out_a) - first1(t_out_a) + 1 !== 13) begin n_fail++; $display("FAIL rt_out_contig got %0d exp 13", last1(t_out_a) - first1(t_out_a) + 1); end
    n_tests++; if (last1(t_busy_a) !== 24) begin n_fail++; $display("FAIL rt_busy_last got %0d exp 24", last1(t_busy_a)); end
    n_tests++; if (cnt1(t_busy_a) !== 17) begin n_fail++; $display("FAIL rt_busy_len got %0d exp 17", cnt1(t_busy_a)); end
    n_tests++; if (cnt1(t_drop_a) !== 0) begin n_fail++; $display("FAIL rt_drop got %0d exp 0", cnt1(t_drop_a)); end
    n_tests++; if (cnt1(t_out_b) !== 8) begin n_fail++; $display("FAIL nrt_out_len got %0d exp 8", cnt1(t_out_b)); end
    n_tests++; if (cnt1(t_drop_b) !== 1) begin n_fail++; $display("FAIL nrt_drop_cnt got %0d exp 1", cnt1(t_drop_b)); end
    n_tests++; if (t_drop_b[13] !== 1'b1) begin n_fail++; $display("FAIL nrt_drop_pos got %b exp 1", t_drop_b[13]); end
    n_tests++; if (cnt1(t_busy_c) !== 13) begin n_fail++; $display("FAIL rt_c_busy_len got %0d exp 13", cnt1(t_busy_c)); end
    // Rise on the last hold cycle: reload beats expiry.
    capture(50, 5, 1, 13, 1);
    n_tests++; if (cnt1(t_out_a) !== 16) begin n_fail++; $display("FAIL rt_last_out_len got %0d exp 16", cnt1(t_out_a)); end
    n_tests++; if (last1(t_out_a) !== 23) begin n_fail++; $display("FAIL rt_last_out_last got %0d exp 23", last1(t_out_a)); end
    n_tests++; if (cnt1(t_out_c) !== 16) begin n_fail++; $display("FAIL rt_last_c_len got %0d exp 16", cnt1(t_out_c)); end
    n_tests++; if (t_drop_b[16] !== 1'b1) begin n_fail++; $display("FAIL nrt_last_drop got %b exp 1", t_drop_b[16]); end
  endtask

  task automatic test_gap();
    // Rise on gap cycle 2.
    capture(50, 5, 1, 16, 1);
    n_tests++; if (cnt1(t_out_a) !== 8) begin n_fail++; $display("FAIL gap_out_len got %0d exp 8", cnt1(t_out_a)); end
    n_tests++; if (cnt1(t_drop_a) !== 1) begin n_fail++; $display("FAIL gap_drop_cnt got %0d exp 1", cnt1(t_drop_a)); end
    n_tests++; if (t_drop_a[19] !== 1'b1) begin n_fail++; $display("FAIL gap_drop_pos got %b exp 1", t_drop_a[19]); end
    n_tests++; if (last1(t_busy_a) !== 19) begin n_fail++; $display("FAIL gap_busy_last got %0d exp 19", last1(t_busy_a)); end
    // Rise on the final gap cycle.
    capture(50, 5, 1, 17, 1);
    n_tests++; if (t_drop_a[20] !== 1'b1) begin n_fail++; $display("FAIL gap_final_drop got %b exp 1", t_drop_a[20]); end
    n_tests++; if (cnt1(t_out_a) !== 8) begin n_fail++; $display("FAIL gap_final_out_len got %0d exp 8", cnt1(t_out_a)); end
    n_tests++; if (cnt1(t_busy_a) !== 12) begin n_fail++; $display("FAIL gap_final_busy_len got %0d exp 12", cnt1(t_busy_a)); end
  endtask

  task automatic test_back_to_back();
    // Rise seen on the first idle cycle after busy falls.
    capture(50, 5, 1, 18, 1);
    n_tests++; if (cnt1(t_out_a) !== 16) begin n_fail++; $display("FAIL b2b_out_len got %0d exp 16", cnt1(t_out_a)); end
    n_tests++; if (t_busy_a[20] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %b exp 0", t_busy_a[20]); end
    n_tests++; if (t_out_a[21] !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got %b exp 1", t_out_a[21]); end
    n_tests++; if (last1(t_out_a) !== 28) begin n_fail++; $display("FAIL b2b_out_last got %0d exp 28", last1(t_out_a)); end
    n_tests++; if (cnt1(t_drop_a) !== 0) begin n_fail++; $display("FAIL b2b_drop got %0d exp 0", cnt1(t_drop_a)); end
    n_tests++; if (cnt1(t_out_c) !== 16) begin n_fail++; $display("FAIL b2b_c_out_len got %0d exp 16", cnt1(t_out_c)); end
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk); in_pulse = 1'b1;
    @(negedge clk); in_pulse = 1'b0;
    repeat (5) @(negedge clk);  // hold cycle 3
    n_tests++; if (out_a !== 1'b1) begin n_fail++; $display("FAIL rmh_pre_out got %b exp 1", out_a); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL rmh_out got %b exp 0", out_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rmh_busy got %b exp 0", busy_a); end
    n_tests++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL rmh_c_busy got %b exp 0", busy_c); end
    @(negedge clk); rst = 1'b0;
    capture(30, -100, 0, -100, 0);
    n_tests++; if (cnt1(t_busy_a) !== 0) begin n_fail++; $display("FAIL rmh_after_busy got %0d exp 0", cnt1(t_busy_a)); end
    n_tests++; if (cnt1(t_out_b) !== 0) begin n_fail++; $display("FAIL rmh_after_out got %0d exp 0", cnt1(t_out_b)); end
  endtask

  task automatic test_held_high();
    capture(130, 5, 100, -100, 0);
    n_tests++; if (cnt1(t_out_a) !== 8) begin n_fail++; $display("FAIL hh_out_len got %0d exp 8", cnt1(t_out_a)); end
    n_tests++; if (first1(t_out_a) !== 8) begin n_fail++; $display("FAIL hh_out_first got %0d exp 8", first1(t_out_a)); end
    n_tests++; if (cnt1(t_busy_a) !== 12) begin n_fail++; $display("FAIL hh_busy_len got %0d exp 12", cnt1(t_busy_a)); end
    n_tests++; if (cnt1(t_drop_a) + cnt1(t_drop_b) !== 0) begin n_fail++; $display("FAIL hh_drop got %0d exp 0", cnt1(t_drop_a) + cnt1(t_drop_b)); end
    n_tests++; if (cnt1(t_busy_c) !== 8) begin n_fail++; $display("FAIL hh_c_busy_len got %0d exp 8", cnt1(t_busy_c)); end
  endtask

  task automatic test_release_high();
    @(negedge clk); rst = 1'b1; in_pulse = 1'b1;
    @(negedge clk); rst = 1'b0;
    capture(60, 0, 40, -100, 0);
    n_tests++; if (cnt1(t_out_a) !== 8) begin n_fail++; $display("FAIL rel_out_len got %0d exp 8", cnt1(t_out_a)); end
    n_tests++; if (first1(t_out_a) !== 2) begin n_fail++; $display("FAIL rel_out_first got %0d exp 2", first1(t_out_a)); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    in_pulse = 1'b0;
    test_reset();
    test_isolated();
    test_retrigger();
    test_gap();
    test_back_to_back();
    test_reset_mid_hold();
    test_held_high();
    test_release_high();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
